// File: rtl/jtag_dr_scan_ctrl.sv
// jtag_dr_scan_ctrl: JTAG data-register scan controller for IDCODE, USER and BYPASS registers.
// Define JTAG_USER_REG_EN to build the 8-bit USER register; otherwise USER decodes as BYPASS.
module jtag_dr_scan_ctrl (
    input  logic       clk_tck,
    input  logic       trst_n,
    input  logic       enable,
    input  logic [3:0] ir,
    input  logic       capture_dr,
    input  logic       shift_dr,
    input  logic       update_dr,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    input  logic [7:0] user_in,
    output logic [7:0] user_out,
    output logic       user_update,
    output logic       short_scan
);
`ifdef JTAG_USER_REG_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif
    localparam logic [31:0] IDCODE_VAL = 32'h000FAF01;
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;
    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} sel_t;
    state_t      state;
    sel_t        sel;
    sel_t        sel_dec;
    logic [5:0]  count;
    logic [5:0]  len;
    logic [31:0] sr;
    logic [31:0] sr_load;
    logic [31:0] sr_shift;
    always_comb begin
        sel_dec  = ir == 4'b1110 ? SEL_IDCODE : (USER_EN && ir == 4'b1010) ? SEL_USER : SEL_BYPASS;
        sr_load  = sel_dec == SEL_IDCODE ? IDCODE_VAL : sel_dec == SEL_USER ? {24'h0, user_in} : 32'h0;
        len      = sel == SEL_IDCODE ? 6'd32 : sel == SEL_USER ? 6'd8 : 6'd1;
        // tdi enters at bit L-1 so it reaches tdo after exactly L shifts
        sr_shift = sel == SEL_IDCODE ? {tdi, sr[31:1]} :
                   sel == SEL_USER   ? {24'h0, tdi, sr[7:1]} : {31'h0, tdi};
    end
    assign tdo    = sr[0];
    assign tdo_en = shift_dr && state != IDLE;
    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            state       <= IDLE;
            sel         <= SEL_BYPASS;
            count       <= 6'd0;
            sr          <= 32'h0;
            user_out    <= 8'h00;
            user_update <= 1'b0;
            short_scan  <= 1'b0;
        end else begin
            user_update <= 1'b0;
            short_scan  <= 1'b0;
            if (enable) begin
                if (capture_dr) begin
                    sel   <= sel_dec;
                    count <= 6'd0;
                    sr    <= sr_load;
                    state <= ARMED;
                end else if (update_dr && state != IDLE) begin
                    state <= IDLE;
                    if (sel == SEL_USER && count == 6'd8) begin
                        user_out    <= sr[7:0];
                        user_update <= 1'b1;
                    end
                    if (count < len)
                        short_scan <= 1'b1;
                end else if (shift_dr && state != IDLE) begin
                    sr    <= sr_shift;
                    state <= SHIFT;
                    count <= count == len ? count : count + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_dr_scan_ctrl.sv
// tb_jtag_dr_scan_ctrl: directed bench with a queue-based scan model checked every cycle.
// Literal expectations follow the JTAG_USER_REG_EN build setting.
module tb_jtag_dr_scan_ctrl;
`ifdef JTAG_USER_REG_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif
    logic       clk_tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] ir = 4'b1111;
    logic       capture_dr = 1'b0;
    logic       shift_dr = 1'b0;
    logic       update_dr = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       tdo_en;
    logic [7:0] user_in = 8'h00;
    logic [7:0] user_out;
    logic       user_update;
    logic       short_scan;
    int  checks = 0;
    int  errors = 0;
    bit  go = 0;
    logic last_tdo;
    jtag_dr_scan_ctrl dut (
        .clk_tck(clk_tck), .trst_n(trst_n), .enable(enable), .ir(ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en), .user_in(user_in),
        .user_out(user_out), .user_update(user_update), .short_scan(short_scan)
    );
    always #5 clk_tck = ~clk_tck;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: the data register is a queue of L bits, head = tdo; a scan is "open" between capture and update
    bit       m_open;
    bit       m_user;
    int       m_len;
    int       m_cnt;
    bit       q[$];
    logic [7:0] m_uo;
    bit       m_uu;
    bit       m_ss;
    always @(posedge clk_tck or negedge trst_n) begin
        logic [31:0] val;
        if (!trst_n) begin
            m_open = 0; m_user = 0; m_len = 1; m_cnt = 0;
            q.delete(); q.push_back(1'b0);
            m_uo = 8'h00; m_uu = 0; m_ss = 0;
        end else begin
            m_uu = 0; m_ss = 0;
            if (enable) begin
                if (capture_dr) begin
                    m_user = USER_EN && ir == 4'b1010;
                    m_len  = ir == 4'b1110 ? 32 : m_user ? 8 : 1;
                    val    = ir == 4'b1110 ? 32'h000FAF01 : m_user ? {24'h0, user_in} : 32'h0;
                    q.delete();
                    for (int i = 0; i < m_len; i++) q.push_back(val[i]);
                    m_cnt  = 0;
                    m_open = 1;
                end else if (update_dr && m_open) begin
                    m_open = 0;
                    if (m_user && m_cnt == 8) begin
                        for (int i = 0; i < 8; i++) m_uo[i] = q[i];
                        m_uu = 1;
                    end
                    m_ss = m_cnt < m_len;
                end else if (shift_dr && m_open) begin
                    q.push_back(tdi);
                    void'(q.pop_front());
                    if (m_cnt < m_len) m_cnt++;
                end
            end
        end
    end
    always @(negedge clk_tck) if (go) begin
        chk("tdo", tdo, q[0]);
        chk("tdo_en", tdo_en, shift_dr && m_open);
        chk("user_out", user_out, m_uo);
        chk("user_update", user_update, m_uu);
        chk("short_scan", short_scan, m_ss);
    end
    task automatic step(input bit c, input bit s, input bit u, input bit t);
        capture_dr = c; shift_dr = s; update_dr = u; tdi = t;
        @(negedge clk_tck);
        last_tdo = tdo;
        @(posedge clk_tck);
        #1;
        capture_dr = 0; shift_dr = 0; update_dr = 0;
    endtask
    initial begin
        logic [31:0] v;
        logic [7:0]  pat;
        #1;
        chk("reset_tdo", tdo, 0);
        chk("reset_user_out", user_out, 8'h00);
        chk("reset_pulses", {user_update, short_scan}, 2'b00);
        @(posedge clk_tck); #1;
        trst_n = 1;
        go = 1;
        step(0, 1, 1, 1);
        chk("idle_ignore_tdo", tdo, 0);
        ir = 4'b1110;
        step(1, 0, 0, 0);
        chk("idcode_first_bit", tdo, 1);
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 0, 0);
            v[i] = last_tdo;
        end
        chk("idcode_read", v, 32'h000FAF01);
        step(0, 0, 1, 0);
        chk("idcode_no_short", short_scan, 0);
        ir = 4'b1010; user_in = 8'h3C; pat = 8'hA5;
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, pat[i]);
            v[i] = last_tdo;
        end
        chk("user_tdo", v[7:0], USER_EN ? 8'h3C : 8'h4A);
        step(0, 0, 1, 0);
        chk("user_out_write", user_out, USER_EN ? 8'hA5 : 8'h00);
        chk("user_update_pulse", user_update, USER_EN);
        step(0, 0, 0, 0);
        chk("user_update_drop", user_update, 0);
        user_in = 8'h77;
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
        step(0, 0, 1, 0);
        chk("short_user_pulse", short_scan, USER_EN);
        chk("short_user_keep", user_out, USER_EN ? 8'hA5 : 8'h00);
        chk("short_user_no_update", user_update, 0);
        ir = 4'b0011;
        step(1, 0, 0, 0);
        step(0, 1, 0, 1); v[0] = last_tdo;
        step(0, 1, 0, 0); v[1] = last_tdo;
        step(0, 1, 0, 1); v[2] = last_tdo;
        chk("bypass_seq", v[2:0], 3'b010);
        step(0, 0, 1, 0);
        ir = 4'b1000;
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        chk("abort_bypass_tdo", tdo, 1);
        ir = 4'b1110;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        enable = 0;
        ir = 4'b0011;
        step(1, 0, 0, 0);
        chk("enable_hold_tdo", tdo, 0);
        enable = 1;
        step(0, 1, 0, 0);
        chk("enable_resume_tdo", tdo, 0);
        step(0, 1, 0, 0);
        chk("enable_resume_tdo2", tdo, 0);
        ir = 4'b1110;
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
        trst_n = 0;
        step(0, 0, 0, 0);
        chk("reset_mid_tdo", tdo, 0);
        trst_n = 1;
        step(0, 0, 1, 0);
        chk("reset_mid_pulses", {user_update, short_scan}, 2'b00);
        chk("reset_mid_tdo2", tdo, 0);
        step(0, 1, 0, 1);
        chk("reset_needs_capture", tdo, 0);
        step(1, 1, 1, 0);
        chk("simul_capture_tdo", tdo, 1);
        chk("simul_no_pulse", {user_update, short_scan}, 2'b00);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("simul_count_zero_short", short_scan, 1);
        step(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_dr_scan_ctrl.md
JTAG_DR_SCAN_CTRL -- requirements
Module: jtag_dr_scan_ctrl

Interface
REQ-001 SHALL have `clk_tck`, input, 1 bit: TCK, the only clock; all state changes on its rising edge.
REQ-002 SHALL have `trst_n`, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have `enable`, input, 1 bit: when low, all state holds and strobes are ignored.
REQ-004 SHALL have `ir`, input, 4 bits: current TAP instruction, sampled only on capture.
REQ-005 SHALL have `capture_dr`, `shift_dr` and `update_dr`, inputs, 1 bit each: TAP state strobes, one TCK each.
REQ-006 SHALL have `tdi`, input, 1 bit: serial data in.
REQ-007 SHALL have `tdo`, output, 1 bit: serial data out, equal to shift register bit 0.
REQ-008 SHALL have `tdo_en`, output, 1 bit: combinational, high when `shift_dr` is high and state is not IDLE.
REQ-009 SHALL have `user_in`, input, 8 bits: value captured into the USER register.
REQ-010 SHALL have `user_out`, output, 8 bits: last committed USER value.
REQ-011 SHALL have `user_update`, output, 1 bit: one-cycle pulse when `user_out` is written.
REQ-012 SHALL have `short_scan`, output, 1 bit: one-cycle pulse when an update follows fewer than L shifts.

Function
REQ-013 SHALL decode instructions as IDCODE=4'b1110 (L=32), USER=4'b1010 (L=8) and BYPASS=4'b1111 (L=1); ABORT=4'b1000 and all other codes SHALL behave as BYPASS.
REQ-014 SHALL implement states IDLE, ARMED and SHIFT.
REQ-015 SHALL, on `capture_dr` in any state, latch the decoded selection and set count to 0.
  - Shift register load: IDCODE → 32'h000FAF01; USER → `user_in`; BYPASS → 0.
  - Next state: ARMED.
REQ-016 SHALL, on `shift_dr` in ARMED or SHIFT, shift right by one within L bits, insert `tdi` at bit L-1, and go to SHIFT.
  - Count saturates at L.
  - Shifting continues past L; each extra `tdi` bit appears on `tdo` L shifts later.
REQ-017 SHALL ignore `shift_dr` and `update_dr` in IDLE, with no output change.
REQ-018 SHALL, on `update_dr` in ARMED or SHIFT, go to IDLE and apply the commit rules below.
  - If selection is USER and count equals 8, load `user_out` from shift register bits [7:0] and pulse `user_update`.
  - If count is less than L, pulse `short_scan` and leave `user_out` unchanged.
REQ-019 SHALL register `user_update` and `short_scan` on the update edge, so each is high for exactly the following cycle.
REQ-020 SHALL apply priority capture > update > shift when strobes coincide; the lower-priority strobes in that cycle are ignored.
REQ-021 SHALL keep `tdo` valid from the capture edge onward, with the first bit shifted out equal to loaded bit 0 (IDCODE bit 0 = 1).

Reset
REQ-022 SHALL, while `trst_n` is low, immediately force:
  - state IDLE, count 0, shift register 0, selection BYPASS;
  - `user_out`=8'h00, `user_update`=0, `short_scan`=0;
  - therefore `tdo`=0 and `tdo_en`=0.
REQ-023 SHALL abandon any in-progress scan on reset with no commit, and SHALL require a new `capture_dr` after reset release before shifting.

Configuration
REQ-024 SHALL, with macro `JTAG_USER_REG_EN` defined, implement the USER register as specified.
REQ-025 SHALL, without `JTAG_USER_REG_EN`, decode USER as BYPASS, hold `user_out` at 8'h00 and hold `user_update` at 0.

Verification
REQ-026 SHALL cover IDCODE read: ir=4'b1110, capture, then 32 shifts with tdi=0 → `tdo` sequence LSB-first equals 32'h000FAF01; then update → no `short_scan`.
REQ-027 SHALL cover USER write: ir=4'b1010, user_in=8'h3C, capture, then 8 shifts of tdi bits of 8'hA5 LSB-first, then update.
  - `tdo` emits 8'h3C LSB-first.
  - `user_out`=8'hA5 and `user_update` is high one cycle.
REQ-028 SHALL cover short USER scan: ir=4'b1010, capture, 5 shifts, update → `short_scan` pulses, `user_out` unchanged, no `user_update`.
REQ-029 SHALL cover bypass: ir=4'b0011, capture, shifts with tdi=1,0,1 → `tdo`=0,1,0 (one-cycle delay).
REQ-030 SHALL cover reset mid-scan: IDCODE capture, 10 shifts, `trst_n` low for 1 cycle, then update strobe.
  - `tdo`=0 and state is IDLE.
  - No `user_update` and no `short_scan`.
REQ-031 SHALL cover simultaneous strobes: `capture_dr`, `shift_dr` and `update_dr` all high with ir=4'b1110 → only the capture takes effect (count 0, `tdo`=1), and with `JTAG_USER_REG_EN` undefined a USER scan of 8'hA5 leaves `user_out`=8'h00.
